// File: rtl/xnor_mac_pkg.sv
// Shared definitions for the XNOR-popcount MAC array.
// Contents:
//   state_t     - controller states (IDLE, RUN, DONE)
//   DEF_WIDTH   - default bits per weight row / input chunk
//   DEF_DEPTH   - default number of weight rows
//   acc_width() - accumulator width able to hold WIDTH*DEPTH without overflow
package xnor_mac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 8;

  // Largest possible sum is width*depth (every bit of every row matching).
  function automatic int acc_width(input int width, input int depth);
    return $clog2(width * depth + 1);
  endfunction

endpackage

// File: rtl/xnor_mac_array_popcount.sv
// Combinational population count of a WIDTH-bit vector.
// Ports:
//   vec  in  WIDTH               vector to count
//   cnt  out clog2(WIDTH+1)      number of set bits in vec
module popcount #(
  parameter int WIDTH = 16,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [CW-1:0]    cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + CW'(vec[i]);
    end
  end

endmodule

// File: rtl/xnor_mac_array.sv
// Binary XNOR-popcount multiply-accumulate array. Holds DEPTH weight rows of
// WIDTH bits; an accumulation streams LEN input chunks, each XNORed with the
// row of the same index and popcounted, and sums the counts into RES.
// Optional feature macro: XNOR_MAC_BIPOLAR_EN (RES = 2*acc - LEN_eff*WIDTH,
// signed); when undefined RES is the unsigned match count.
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   WE, WADDR, WDATA    weight row write (honoured only while idle)
//   START, LEN          begin an accumulation of LEN rows (0 or >DEPTH = DEPTH)
//   IN_VALID, IN_READY, INPUT   input chunk stream
//   RES_VALID, RES_READY, RES   result handshake
//   BUSY                controller not idle
module xnor_mac_array
  import xnor_mac_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int ACC_W = acc_width(WIDTH, DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             WE,
  input  logic [AW-1:0]    WADDR,
  input  logic [WIDTH-1:0] WDATA,
  input  logic             START,
  input  logic [AW:0]      LEN,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] INPUT,
  output logic             RES_VALID,
  input  logic             RES_READY,
  output logic [ACC_W:0]   RES,
  output logic             BUSY
);

  localparam int PW = $clog2(WIDTH + 1);

  state_t           state_reg;
  logic [WIDTH-1:0] weight_reg [DEPTH];
  logic [ACC_W-1:0] acc_reg;
  logic [AW-1:0]    k_reg;
  logic [AW:0]      len_reg;
  logic [ACC_W:0]   res_reg;

  logic [AW:0]      len_eff;
  logic [WIDTH-1:0] match_vec;
  logic [PW-1:0]    match_cnt;
  logic [ACC_W-1:0] acc_next;
  logic [ACC_W:0]   res_next;
  logic             last_chunk;

  // Weight rows are only writable while idle so a running accumulation
  // always sees a consistent set of rows.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        weight_reg[i] <= '0;
      end
    end else if (WE && state_reg == IDLE) begin
      weight_reg[WADDR] <= WDATA;
    end
  end

  assign len_eff = (LEN == '0 || LEN > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : LEN;

  assign match_vec = ~(INPUT ^ weight_reg[k_reg]);

  popcount #(.WIDTH(WIDTH)) u_popcount (
    .vec (match_vec),
    .cnt (match_cnt)
  );

  assign acc_next   = acc_reg + ACC_W'(match_cnt);
  assign last_chunk = ({1'b0, k_reg} == len_reg - 1'b1);

`ifdef XNOR_MAC_BIPOLAR_EN
  // Bipolar dot product: each match is +1, each mismatch -1. The true value
  // fits in ACC_W+1 signed bits, so modular arithmetic gives the exact result.
  assign res_next = {acc_next, 1'b0} - ((ACC_W+1)'(len_reg) * (ACC_W+1)'(WIDTH));
`else
  assign res_next = {1'b0, acc_next};
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      k_reg     <= '0;
      len_reg   <= '0;
      res_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (START) begin
            state_reg <= RUN;
            len_reg   <= len_eff;
            acc_reg   <= '0;
            k_reg     <= '0;
          end
        end
        RUN: begin
          if (IN_VALID) begin
            acc_reg <= acc_next;
            k_reg   <= k_reg + 1'b1;
            if (last_chunk) begin
              res_reg   <= res_next;
              state_reg <= DONE;
            end
          end
        end
        DONE: begin
          if (RES_READY) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign IN_READY  = (state_reg == RUN);
  assign RES_VALID = (state_reg == DONE);
  assign BUSY      = (state_reg != IDLE);
  assign RES       = res_reg;

endmodule

// File: tb/tb_xnor_mac_array.sv
// Directed self-checking bench for xnor_mac_array (WIDTH=16, DEPTH=8).
// Expected results follow the active XNOR_MAC_BIPOLAR_EN setting.
module tb_xnor_mac_array;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [2:0]  waddr;
  logic [15:0] wdata;
  logic        start;
  logic [3:0]  len;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        res_valid;
  logic        res_ready;
  logic [8:0]  res;
  logic        busy;

  int checks = 0;
  int errors = 0;

`ifdef XNOR_MAC_BIPOLAR_EN
  localparam logic [8:0] EXP_T2 = 9'h1F0;  // -16
`else
  localparam logic [8:0] EXP_T2 = 9'd0;
`endif

  xnor_mac_array #(.WIDTH(16), .DEPTH(8)) dut (
    .CLK       (clk),
    .RST       (rst),
    .WE        (we),
    .WADDR     (waddr),
    .WDATA     (wdata),
    .START     (start),
    .LEN       (len),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .INPUT     (in_data),
    .RES_VALID (res_valid),
    .RES_READY (res_ready),
    .RES       (res),
    .BUSY      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_row(input logic [2:0] a, input logic [15:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic start_run(input logic [3:0] l);
    start = 1'b1; len = l;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [15:0] d);
    in_valid = 1'b1; in_data = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic take_result(input string tag);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({tag, "_busy_after"}, 16'(busy), 16'd0);
    check({tag, "_valid_after"}, 16'(res_valid), 16'd0);
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; start = 1'b0; len = '0;
    in_valid = 1'b0; in_data = '0; res_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", 16'(in_ready), 16'd0);
    check("rst_res_valid", 16'(res_valid), 16'd0);
    check("rst_res", 16'(res), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    rst = 1'b0;
    tick();

    // T1: all-match single row
    write_row(3'd0, 16'hFFFF);
    start_run(4'd1);
    check("t1_busy", 16'(busy), 16'd1);
    check("t1_in_ready", 16'(in_ready), 16'd1);
    check("t1_valid_early", 16'(res_valid), 16'd0);
    send(16'hFFFF);
    check("t1_valid", 16'(res_valid), 16'd1);
    check("t1_res", 16'(res), 16'd16);
    check("t1_in_ready_done", 16'(in_ready), 16'd0);
    take_result("t1");

    // T2: all-mismatch single row
    start_run(4'd1);
    send(16'h0000);
    check("t2_valid", 16'(res_valid), 16'd1);
    check("t2_res", 16'(res), 16'(EXP_T2));
    take_result("t2");

    // T3: LEN=0 means full depth, gapped input, delayed consumer
    for (int i = 0; i < 8; i++) write_row(3'(i), 16'hA5A5);
    start_run(4'd0);
    for (int i = 0; i < 8; i++) begin
      send(16'hA5A5);
      if (i == 6) check("t3_not_done_at7", 16'(res_valid), 16'd0);
      if (i < 7) tick();
    end
    check("t3_valid", 16'(res_valid), 16'd1);
    check("t3_res", 16'(res), 16'd128);
    for (int j = 0; j < 3; j++) begin
      start = (j == 1);  // START while DONE must be ignored
      tick();
      check("t3_hold_valid", 16'(res_valid), 16'd1);
      check("t3_hold_res", 16'(res), 16'd128);
    end
    start = 1'b0;
    take_result("t3");

    // T4: write during RUN is ignored
    write_row(3'd3, 16'hFFFF);
    start_run(4'd4);
    send(16'hA5A5);
    we = 1'b1; waddr = 3'd3; wdata = 16'h0000;
    tick();
    we = 1'b0;
    check("t4_busy_mid", 16'(busy), 16'd1);
    send(16'hA5A5);
    send(16'hA5A5);
    send(16'hFFFF);
    check("t4_valid", 16'(res_valid), 16'd1);
    check("t4_res", 16'(res), 16'd64);
    take_result("t4");

    // T5: asynchronous reset mid-run
    start_run(4'd4);
    send(16'hA5A5);
    send(16'hA5A5);
    rst = 1'b1;
    #1;
    check("t5_rst_busy", 16'(busy), 16'd0);
    check("t5_rst_in_ready", 16'(in_ready), 16'd0);
    check("t5_rst_valid", 16'(res_valid), 16'd0);
    check("t5_rst_res", 16'(res), 16'd0);
    tick();
    rst = 1'b0;
    tick();
    start_run(4'd1);
    send(16'h0000);
    check("t5_res_cleared_row", 16'(res), 16'd16);
    take_result("t5");

    // T6: write and START in the same cycle
    we = 1'b1; waddr = 3'd0; wdata = 16'h00FF; start = 1'b1; len = 4'd1;
    tick();
    we = 1'b0; start = 1'b0;
    send(16'h00FF);
    check("t6_valid", 16'(res_valid), 16'd1);
    check("t6_res", 16'(res), 16'd16);
    take_result("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xnor_mac_array.md
# xnor_mac_array

- Parametrised binary XNOR-popcount multiply-accumulate array, the multi-row, multi-bit successor of the single compute bitcell.
- Holds DEPTH weight rows of WIDTH bits in flop-based storage.
- Accepts an input activation vector as a stream of WIDTH-bit chunks, one chunk per row. Each chunk is XNORed with its row and popcounted, and the counts are summed into one dot-product result.
- Sits between the weight loader and the neuron/activation stage of the BNN datapath.

## Interface
- WIDTH, 16, bits per weight row and per input chunk
- DEPTH, 8, number of weight rows (power of two, ≥2)
- Derived (localparam): AW = clog2(DEPTH); ACC_W = clog2(WIDTH*DEPTH+1)
- CLK  in  1  clock, all state on rising edge
- RST  in  1  reset, asynchronous, active-high
- WE  in  1  write enable for weight storage
- WADDR  in  AW  write row address
- WDATA  in  WIDTH  write row data
- START  in  1  begin an accumulation
- LEN  in  AW+1  rows/chunks in this accumulation, sampled at START
- IN_VALID  in  1  input chunk valid
- IN_READY  out  1  array accepts chunk
- INPUT  in  WIDTH  input activation chunk
- RES_VALID  out  1  result valid
- RES_READY  in  1  consumer takes result
- RES  out  ACC_W+1  result
- BUSY  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, RUN, DONE.
- Weight writes:
  - Accepted only in IDLE. WE=1 writes WDATA to row WADDR at the edge.
  - WE in RUN/DONE is ignored; storage is unchanged.
- IDLE→RUN on START=1:
  - Latch LEN; LEN=0 or LEN>DEPTH is treated as DEPTH.
  - Clear accumulator and row counter k.
  - WE and START asserted in the same cycle: the write completes and START is accepted. RUN uses the updated row.
- RUN:
  - IN_READY=1.
  - On IN_VALID&IN_READY: acc += popcount(~(INPUT ^ row[k])), then k += 1.
  - IN_VALID low: state held, no update.
  - Acceptance of chunk LEN-1 moves the FSM to DONE.
- DONE:
  - RES_VALID=1 and RES is held stable until RES_VALID&RES_READY, which moves the FSM to IDLE.
  - START in DONE is ignored.
- Arithmetic:
  - acc is ACC_W bits unsigned and cannot overflow (max WIDTH*DEPTH).
  - RES is ACC_W+1 bits; its encoding is given under Configuration.
- Reset:
  - Any state goes to IDLE, including mid-RUN or mid-DONE.
  - acc, k and latched LEN are cleared; all weight rows are cleared to 0.
  - An in-flight accumulation is discarded.

## Timing
- Reset values: IN_READY=0, RES_VALID=0, RES=0, BUSY=0.
- START seen at edge n: BUSY=1 and IN_READY=1 from cycle n+1.
- One chunk per cycle maximum; the array applies no backpressure within RUN.
- Last chunk accepted at edge m: RES_VALID=1 from cycle m+1. Result latency is 1 cycle after the final chunk.
- Minimum operation: LEN cycles in RUN + 1 cycle in DONE.
- RES_VALID&RES_READY at edge p: RES_VALID=0, BUSY=0 from p+1. START can be accepted at edge p+1.
- RES is registered; IN_READY and BUSY are decoded from the state register only.

## Configuration
- Macro: XNOR_MAC_BIPOLAR_EN.
- Defined:
  - RES is signed two's complement: RES = 2*acc − LEN_eff*WIDTH.
  - This is the bipolar ±1 dot product. Range −WIDTH*DEPTH … +WIDTH*DEPTH.
- Undefined:
  - RES = acc, zero-extended, unsigned.
  - No multiplier/subtractor logic is present.

## Structure
- Package xnor_mac_pkg holds:
  - state enum (IDLE, RUN, DONE)
  - default WIDTH/DEPTH constants
  - ACC_W computation function
- Sub-module popcount: combinational, parametrised by WIDTH, with output width clog2(WIDTH+1). It is instantiated once on the XNOR vector.
- Weight storage, FSM and accumulator are in the top module.

## Test plan
All scenarios use WIDTH=16, DEPTH=8.
- Write row0=16'hFFFF; START LEN=1; INPUT=16'hFFFF → RES=16 in both modes; RES_VALID one cycle after acceptance.
- Row0=16'hFFFF; LEN=1; INPUT=16'h0000 → RES=0 (unsigned) / −16 (bipolar).
- All rows 16'hA5A5; START LEN=0 (treated as 8); 8 matching chunks with IN_VALID gaps every other cycle; RES_READY held low 3 cycles → RES=128 in both modes, stable while held; BUSY drops the cycle after the handshake.
- During RUN, WE=1 to row3 with 16'h0000 (row3 was 16'hFFFF); later chunk3=16'hFFFF → row3 unchanged and contributes 16.
- Assert RST after 2 chunks of an LEN=4 run → all outputs 0 immediately. Then START LEN=1 with INPUT=16'h0000 against cleared row0 → RES=16.
- WE (row0=16'h00FF) and START LEN=1 in the same cycle; INPUT=16'h00FF → RES=16, showing the new row was used.
